// File: rtl/rx_ins_queue_pkg.sv
// Shared constants for the rx instruction queue: instruction word layout,
// issue FSM state encoding, opcode values and field-extraction helpers.
package INS_CONST;

  localparam int unsigned INST_W     = 64;
  localparam int unsigned OPCODE_MSB = 61;
  localparam int unsigned OPCODE_LSB = 58;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int unsigned BUF_ID_MSB = 57;
  localparam int unsigned BUF_ID_LSB = 52;
  localparam int unsigned BUF_ID_W   = BUF_ID_MSB - BUF_ID_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP      = 4'h0,
    OP_RX_CFG   = 4'h1,
    OP_RX_START = 4'h2,
    OP_RX_STOP  = 4'h3
  } opcode_t;

  // Opcode field of an instruction word.
  function automatic opcode_t ins_opcode(input logic [INST_W-1:0] w);
    return opcode_t'(w[OPCODE_MSB:OPCODE_LSB]);
  endfunction

  // Buffer id field of an instruction word.
  function automatic logic [BUF_ID_W-1:0] ins_buf_id(input logic [INST_W-1:0] w);
    return w[BUF_ID_MSB:BUF_ID_LSB];
  endfunction

endpackage

// File: rtl/rx_ins_queue_fifo.sv
// Show-ahead synchronous FIFO holding queued rx instructions. Pointers carry
// an extra msb so full and empty are distinguishable without a counter.
module rx_ins_fifo
  import INS_CONST::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = INST_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign level   = wptr - rptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  // Storage write; contents need no reset since empty gates every read use.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= din;
    end
  end

  // Wrap-around read/write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/rx_ins_queue.sv
// rx instruction queue: buffers decoded instructions and issues them one at a
// time to the rx configuration stage, holding any instruction whose buffer id
// is still marked busy by an earlier issue until the compute side releases it.
// Optional macro RX_QUEUE_STAT_EN adds stall_cycles / issue_count counters.
module rx_ins_queue
  import INS_CONST::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned BUF_NUM = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_W-1:0]        in_ins,
  output logic                     ins_valid,
  input  logic                     ins_ready,
  output logic [INST_W-1:0]        ins,
  input  logic                     rx_done_pulse,
  input  logic                     buf_release,
  input  logic [BUF_ID_W-1:0]      buf_release_id,
  output logic [BUF_NUM-1:0]       busy_mask,
  output logic [$clog2(DEPTH):0]   queue_level,
`ifdef RX_QUEUE_STAT_EN
  output logic [31:0]              stall_cycles,
  output logic [15:0]              issue_count,
`endif
  output logic                     idle
);

  state_t                state;
  state_t                state_d;
  logic                  ins_valid_d;
  logic [INST_W-1:0]     ins_d;
  logic [BUF_NUM-1:0]    busy_d;
  logic [INST_W-1:0]     head;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  handshake;
  logic [BUF_ID_W-1:0]   head_buf_id;
  logic                  head_busy;

  assign in_ready    = !full;
  assign push        = in_valid && in_ready;
  assign handshake   = ins_valid && ins_ready;
  assign head_buf_id = ins_buf_id(head);
  assign head_busy   = busy_mask[head_buf_id];
  assign idle        = (state == ST_IDLE) && empty;

  rx_ins_fifo #(
    .DEPTH (DEPTH),
    .W     (INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (handshake),
    .din   (in_ins),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (queue_level)
  );

  // Issue FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next state plus next values for the registered issue outputs. A write
  // seen in IDLE moves straight to CHECK so the head is evaluated the first
  // cycle it becomes visible.
  always_comb begin
    state_d     = state;
    ins_valid_d = ins_valid;
    ins_d       = ins;
    unique case (state)
      ST_IDLE: begin
        if (push || !empty) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!empty && !head_busy) begin
          state_d     = ST_ISSUE;
          ins_valid_d = 1'b1;
          ins_d       = head;
        end
      end
      ST_ISSUE: begin
        if (ins_ready) begin
          state_d     = ST_WAIT;
          ins_valid_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (rx_done_pulse) state_d = empty ? ST_IDLE : ST_CHECK;
      end
      default: begin
        state_d     = ST_IDLE;
        ins_valid_d = 1'b0;
      end
    endcase
  end

  // Registered instruction output; ins only changes on entry to ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_valid <= 1'b0;
      ins       <= '0;
    end else begin
      ins_valid <= ins_valid_d;
      ins       <= ins_d;
    end
  end

  // Busy mask update: a set on handshake wins over a same-cycle release.
  always_comb begin
    busy_d = busy_mask;
    if (buf_release && (32'(buf_release_id) < BUF_NUM)) begin
      busy_d[buf_release_id] = 1'b0;
    end
    if (handshake) begin
      busy_d[ins_buf_id(ins)] = 1'b1;
    end
  end

  // Busy mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_mask <= '0;
    else     busy_mask <= busy_d;
  end

`ifdef RX_QUEUE_STAT_EN
  // Wrapping counters: blocked CHECK cycles and completed handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      if ((state == ST_CHECK) && !empty && head_busy) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (handshake) begin
        issue_count <= issue_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_ins_queue.sv
// Directed bench for rx_ins_queue: issue latency, busy blocking and release,
// full/wrap ordering, output stall stability, set/release collision, reset.
module tb_rx_ins_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_ins;
  logic         ins_valid;
  logic         ins_ready;
  logic [63:0]  ins;
  logic         rx_done_pulse;
  logic         buf_release;
  logic [5:0]   buf_release_id;
  logic [63:0]  busy_mask;
  logic [3:0]   queue_level;
  logic         idle;
`ifdef RX_QUEUE_STAT_EN
  logic [31:0]  stall_cycles;
  logic [15:0]  issue_count;
`endif

  int total = 0;
  int bad   = 0;

  rx_ins_queue #(.DEPTH(8), .BUF_NUM(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ins         (in_ins),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .rx_done_pulse  (rx_done_pulse),
    .buf_release    (buf_release),
    .buf_release_id (buf_release_id),
    .busy_mask      (busy_mask),
    .queue_level    (queue_level),
`ifdef RX_QUEUE_STAT_EN
    .stall_cycles   (stall_cycles),
    .issue_count    (issue_count),
`endif
    .idle           (idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [3:0] op, input logic [5:0] id, input logic [15:0] tg);
    return {2'b00, op, id, 36'd0, tg};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w1, w2, w3a, w3b, wa, wb, w7;
    logic [63:0] words [20];
    logic [63:0] exp_mask;
    int          idx_in, idx_out, lvl, seen;
    logic        acc, hs;

    rst = 1'b1; in_valid = 1'b0; in_ins = '0; ins_ready = 1'b0;
    rx_done_pulse = 1'b0; buf_release = 1'b0; buf_release_id = '0;
    exp_mask = '0;

    // Reset values
    tick(); tick();
    check("rst_ins_valid", 64'(ins_valid), 64'd0);
    check("rst_ins", ins, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_level", 64'(queue_level), 64'd0);
    check("rst_busy", busy_mask, 64'd0);
    rst = 1'b0;
    tick();

    // Single write of buf 5: ins_valid at N+2; next one waits for done
    w1 = mk(4'h1, 6'd5, 16'h0011);
    w2 = mk(4'h1, 6'd6, 16'h0022);
    ins_ready = 1'b1;
    in_ins = w1; in_valid = 1'b1;
    tick();
    in_ins = w2;
    check("t1_n1_valid", 64'(ins_valid), 64'd0);
    check("t1_n1_level", 64'(queue_level), 64'd1);
    check("t1_n1_idle", 64'(idle), 64'd0);
    tick();
    in_valid = 1'b0;
    check("t1_n2_valid", 64'(ins_valid), 64'd1);
    check("t1_n2_ins", ins, w1);
    tick();
    check("t1_post_valid", 64'(ins_valid), 64'd0);
    check("t1_busy5", 64'(busy_mask[5]), 64'd1);
    check("t1_post_level", 64'(queue_level), 64'd1);
    tick(); tick();
    check("t1_hold_wait", 64'(ins_valid), 64'd0);
    rx_done_pulse = 1'b1; tick(); rx_done_pulse = 1'b0;
    check("t1_check_valid", 64'(ins_valid), 64'd0);
    tick();
    check("t1_second_valid", 64'(ins_valid), 64'd1);
    check("t1_second_ins", ins, w2);
    tick();
    rx_done_pulse = 1'b1; tick(); rx_done_pulse = 1'b0;
    check("t1_idle", 64'(idle), 64'd1);
    check("t1_mask", busy_mask, 64'h60);
    buf_release = 1'b1; buf_release_id = 6'd5; tick();
    buf_release_id = 6'd6; tick();
    buf_release = 1'b0;
    check("t1_mask_clear", busy_mask, 64'd0);

    // Two instructions for buf 3: second blocked until release, then +2
    w3a = mk(4'h2, 6'd3, 16'h0031);
    w3b = mk(4'h2, 6'd3, 16'h0032);
    in_ins = w3a; in_valid = 1'b1; tick();
    in_ins = w3b; tick();
    in_valid = 1'b0;
    check("t2_first_ins", ins, w3a);
    tick();
    check("t2_busy3", 64'(busy_mask[3]), 64'd1);
    check("t2_level", 64'(queue_level), 64'd1);
    rx_done_pulse = 1'b1; tick(); rx_done_pulse = 1'b0;
    check("t2_blocked_c1", 64'(ins_valid), 64'd0);
    tick(); tick(); tick();
    check("t2_blocked_c4", 64'(ins_valid), 64'd0);
    buf_release = 1'b1; buf_release_id = 6'd3; tick();
    buf_release = 1'b0;
    check("t2_rel_plus1", 64'(ins_valid), 64'd0);
    tick();
    check("t2_rel_plus2_valid", 64'(ins_valid), 64'd1);
    check("t2_rel_plus2_ins", ins, w3b);
    tick();
    rx_done_pulse = 1'b1; tick(); rx_done_pulse = 1'b0;
    buf_release = 1'b1; buf_release_id = 6'd3; tick();
    buf_release = 1'b0;
    check("t2_mask_clear", busy_mask, 64'd0);
    check("t2_idle", 64'(idle), 64'd1);

    // Fill to full with downstream stalled, then stream 20 words with wrap
    for (int i = 0; i < 20; i++) words[i] = mk(4'h2, 6'(10 + i), 16'(i));
    ins_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_ins = words[i];
      tick();
    end
    in_ins = words[8];
    check("t3_full_in_ready", 64'(in_ready), 64'd0);
    check("t3_full_level", 64'(queue_level), 64'd8);
    check("t3_full_ins", ins, words[0]);
    idx_in = 8; idx_out = 0; lvl = 8;
    ins_ready = 1'b1; rx_done_pulse = 1'b1;
    for (int cyc = 0; cyc < 200 && idx_out < 20; cyc++) begin
      acc = in_valid && in_ready;
      hs  = ins_valid && ins_ready;
      if (hs) begin
        check("t3_order", ins, words[idx_out]);
        idx_out++;
      end
      tick();
      if (acc) idx_in++;
      lvl = lvl + (acc ? 1 : 0) - (hs ? 1 : 0);
      if (idx_in < 20) in_ins = words[idx_in];
      else             in_valid = 1'b0;
      check("t3_level", 64'(queue_level), 64'(lvl));
    end
    check("t3_drained", 64'(idx_out), 64'd20);
    tick();
    rx_done_pulse = 1'b0; ins_ready = 1'b0;
    for (int i = 10; i < 30; i++) exp_mask[i] = 1'b1;
    check("t3_idle", 64'(idle), 64'd1);
    check("t3_mask", busy_mask, exp_mask);

    // Output stalled 5 cycles: ins stable, exactly one pop on handshake
    wa = mk(4'h3, 6'd40, 16'h0044);
    wb = mk(4'h3, 6'd41, 16'h0045);
    in_ins = wa; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    in_ins = wb; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_valid", 64'(ins_valid), 64'd1);
      check("t4_stall_ins", ins, wa);
      tick();
      in_valid = 1'b0;
    end
    check("t4_level_before", 64'(queue_level), 64'd2);
    ins_ready = 1'b1; tick(); ins_ready = 1'b0;
    exp_mask[40] = 1'b1;
    check("t4_post_valid", 64'(ins_valid), 64'd0);
    check("t4_one_pop", 64'(queue_level), 64'd1);
    check("t4_mask", busy_mask, exp_mask);
    rx_done_pulse = 1'b1; tick(); rx_done_pulse = 1'b0;
    ins_ready = 1'b1; tick();
    check("t4_next_ins", ins, wb);
    tick();
    ins_ready = 1'b0;
    rx_done_pulse = 1'b1; tick(); rx_done_pulse = 1'b0;
    exp_mask[41] = 1'b1;
    check("t4_idle", 64'(idle), 64'd1);

    // Release of id 7 colliding with its issue; release of clear id 9
    w7 = mk(4'h1, 6'd7, 16'h0077);
    ins_ready = 1'b1;
    in_ins = w7; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    check("t5_valid", 64'(ins_valid), 64'd1);
    buf_release = 1'b1; buf_release_id = 6'd7; tick();
    buf_release = 1'b0;
    exp_mask[7] = 1'b1;
    check("t5_bit7_kept", 64'(busy_mask[7]), 64'd1);
    check("t5_bit9_clear", 64'(busy_mask[9]), 64'd0);
    buf_release = 1'b1; buf_release_id = 6'd9; tick();
    buf_release = 1'b0;
    check("t5_mask_noop", busy_mask, exp_mask);
    rx_done_pulse = 1'b1; tick(); rx_done_pulse = 1'b0;
    check("t5_idle", 64'(idle), 64'd1);

    // Reset in WAIT with 3 queued
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_ins = mk(4'h1, 6'(50 + i), 16'(i));
      tick();
    end
    in_valid = 1'b0;
    check("t6_level3", 64'(queue_level), 64'd3);
    check("t6_wait_valid", 64'(ins_valid), 64'd0);
`ifdef RX_QUEUE_STAT_EN
    check("t6_issue_count", 64'(issue_count), 64'd28);
    check("t6_stall_cycles", 64'(stall_cycles), 64'd4);
`endif
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(ins_valid), 64'd0);
    check("t6_rst_ins", ins, 64'd0);
    check("t6_rst_level", 64'(queue_level), 64'd0);
    check("t6_rst_busy", busy_mask, 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd1);
    check("t6_rst_idle", 64'(idle), 64'd1);
`ifdef RX_QUEUE_STAT_EN
    check("t6_rst_issue_count", 64'(issue_count), 64'd0);
    check("t6_rst_stall", 64'(stall_cycles), 64'd0);
`endif
    tick(); tick();
    rst = 1'b0;
    ins_ready = 1'b1; rx_done_pulse = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ins_valid) seen++;
    end
    rx_done_pulse = 1'b0;
    check("t6_no_issue", 64'(seen), 64'd0);
    check("t6_final_idle", 64'(idle), 64'd1);
    check("t6_final_level", 64'(queue_level), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_ins_queue.md
RX_INS_QUEUE -- requirements
Module: rx_ins_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, instruction FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter BUF_NUM, default 64, number of buffer ids tracked (one per 6-bit buf_id).
REQ-003 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: in_valid  in  1; in_ready  out  1; in_ins  in  INST_W. Instruction input from the instruction decoder.
REQ-006 SHALL have ports: ins_valid  out  1; ins_ready  in  1; ins  out  INST_W. Instruction output to the rx configuration stage.
REQ-007 SHALL have ports: rx_done_pulse  in  1  one-cycle completion of the issued instruction.
REQ-008 SHALL have ports: buf_release  in  1; buf_release_id  in  6. Pulse from the compute side freeing a buffer id.
REQ-009 SHALL have ports: busy_mask  out  BUF_NUM; queue_level  out  clog2(DEPTH)+1; idle  out  1.

Function
REQ-010 SHALL decode opcode = ins[61:58] and buf_id = ins[57:52] from the FIFO head.
REQ-011 SHALL drive in_ready = !full; a write occurs on in_valid && in_ready.
REQ-012 SHALL provide no bypass: a word written to an empty FIFO in cycle N is first visible at the head in cycle N+1.
REQ-013 SHALL run an issue FSM with these states:
- IDLE: FIFO empty.
- CHECK: head present; go to ISSUE when busy_mask[buf_id]==0, else stay.
- ISSUE: ins_valid=1 held until ins_ready.
- WAIT: wait for rx_done_pulse.
REQ-014 SHALL register ins_valid and ins in the CHECK->ISSUE transition; with an idle buffer, earliest ins_valid is cycle N+2 for a write in cycle N.
REQ-015 SHALL keep ins stable while ins_valid=1 and !ins_ready.
REQ-016 SHALL, on handshake (ins_valid && ins_ready), pop the FIFO, set busy_mask[buf_id], deassert ins_valid next cycle and enter WAIT.
REQ-017 SHALL, on rx_done_pulse in WAIT, go to CHECK if the FIFO is non-empty, else IDLE; rx_done_pulse outside WAIT SHALL be ignored.
REQ-018 SHALL give at most one instruction outstanding at a time.
REQ-019 SHALL clear busy_mask[buf_release_id] on buf_release. A release in the same cycle as a set of the same id SHALL leave the bit set. A release of a clear bit is a no-op.
REQ-020 SHALL keep queue_level exact under simultaneous push and pop (level unchanged).
REQ-021 SHALL drive idle=1 iff state==IDLE and the FIFO is empty.

Reset
REQ-022 SHALL, on reset, set: state=IDLE, FIFO empty, queue_level=0, busy_mask=0, ins_valid=0, ins=0, in_ready=1, idle=1.
REQ-023 SHALL discard queued and in-flight instructions when reset is asserted mid-operation; no ins_valid pulse may follow reset release until a new write.

Configuration
REQ-024 SHALL support macro RX_QUEUE_STAT_EN. When defined, it adds outputs stall_cycles (32-bit: cycles in CHECK with the head blocked by busy) and issue_count (16-bit: handshakes), both wrapping and reset to 0. When undefined, these ports and counters SHALL be absent and all other behaviour identical.

Structure
REQ-025 SHALL take the field positions (opcode, buf_id msb/lsb), INST_W, FSM state encoding and opcode constants from package INS_CONST; no local duplicates.
REQ-026 SHALL place the storage in sub-module rx_ins_fifo: synchronous, show-ahead, DEPTH x INST_W, async reset, full/empty/level outputs, wrap-around pointers with an extra msb.

Verification
REQ-027 SHALL cover: single write of buf_id 5, ins_ready=1 -> ins_valid at N+2; busy_mask[5]=1 after handshake; next instruction issued only after rx_done_pulse.
REQ-028 SHALL cover: two instructions for buf_id 3, done pulses given, no release -> second held in CHECK; buf_release_id=3 -> issued 2 cycles later.
REQ-029 SHALL cover: write 8 words with downstream stalled -> in_ready=0 and queue_level=8. Push during pop at full -> no loss, FIFO order preserved over 20 words with wrap.
REQ-030 SHALL cover: ins_ready held low 5 cycles during ISSUE -> ins stable and valid; exactly one pop.
REQ-031 SHALL cover: buf_release id 7 same cycle as issue of id 7 -> bit 7 remains 1. Release of id 9 while clear -> no change.
REQ-032 SHALL cover: rst asserted in WAIT with 3 queued -> all outputs at reset values immediately; no issue after release. With RX_QUEUE_STAT_EN, counters match scoreboard counts.
